alu_share_ctrl: RTL and testbench
=================================

// Module: alu_share_ctrl
//
// PURPOSE
//   Arbitrates and sequences one shared 64-bit ALU (ADD/SUB/AND/XOR) between two requesters.
//   Requester 0 is the execute stage; requester 1 is the address/PC-update path.
//   Accepts one operation at a time and drives the ALU from registered operands.
//   Returns the registered result plus Y86 condition codes (ZF, SF, OF) through a valid/ready response port.
//
// PARAMETERS
//   WIDTH   64   operand/result width in bits
//
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous reset, active-high
//   req0_valid   in   1      requester 0 has an operation
//   req0_ready   out  1      requester 0 operation accepted this cycle
//   req0_fn      in   2      op code: 0 ADD, 1 SUB, 2 AND, 3 XOR
//   req0_a       in   WIDTH  operand A
//   req0_b       in   WIDTH  operand B
//   req1_valid / req1_ready / req1_fn / req1_a / req1_b   same as req0_*, for requester 1
//   resp_valid   out  1      response valid
//   resp_ready   in   1      consumer takes response
//   resp_id      out  1      index of requester that issued the op
//   resp_y       out  WIDTH  result
//   resp_cc      out  3      {OF, SF, ZF}
//
// BEHAVIOUR
//   - Reset (async): state=IDLE, rr_ptr=0, all outputs 0, operand/result registers 0.
//   - Reset mid-operation drops the in-flight op; no response is produced for it.
//   - FSM states IDLE -> EXEC -> RESP -> IDLE.
//   - IDLE:
//     - Grant goes to rr_ptr if its valid is high, else to the other requester if its valid is high.
//     - reqN_ready is combinational, asserted only in IDLE, only for the granted requester.
//     - Accept happens on valid&&ready: capture fn, a, b and id; go to EXEC.
//     - Requesters hold valid and fields stable until ready.
//   - EXEC (1 cycle):
//     - ALU evaluates the captured operands; register y and cc; go to RESP.
//   - RESP:
//     - resp_valid=1; resp_id/resp_y/resp_cc are held stable while resp_valid&&!resp_ready.
//     - On resp_ready: resp_valid drops the next cycle, rr_ptr <= ~resp_id, return to IDLE.
//   - Timing:
//     - Accept in cycle N gives resp_valid at N+2.
//     - Peak throughput is 1 op per 3 cycles; there is no accept while busy.
//   - Simultaneous valids: rr_ptr requester wins. The loser stays pending and wins next, since rr_ptr flips.
//   - Arithmetic, modulo 2^WIDTH:
//     - ADD y=a+b; SUB y=a-b; AND y=a&b; XOR y=a^b.
//   - Condition codes:
//     - ZF = (y==0).
//     - SF = y[WIDTH-1].
//     - OF for ADD = (a[msb]==b[msb]) && (y[msb]!=a[msb]).
//     - OF for SUB = (a[msb]!=b[msb]) && (y[msb]!=a[msb]).
//     - OF for AND and XOR = 0.
//   - Wrap-around: carry-out is discarded, e.g. ADD 0xFFFF_FFFF_FFFF_FFFF+1 gives y=0, ZF=1, OF=0.
//
// STRUCTURE
//   - alu_pkg (shared package):
//     - fn codes FN_ADD/FN_SUB/FN_AND/FN_XOR.
//     - FSM state encoding ST_IDLE/ST_EXEC/ST_RESP.
//     - CC bit indices CC_ZF=0, CC_SF=1, CC_OF=2.
//   - Sub-module alu_core (purely combinational): inputs fn, a, b; outputs y, cc.
//     - One instance, fed from the operand registers.
//   - alu_share_ctrl holds the FSM, the round-robin pointer, the operand and result registers, and the grant logic.
//
// TESTING
//   1. Single AND op:
//      - Stimulus: req0 fn=2, a=0x3FFFFF, b=0x7FF, resp_ready=1.
//      - Response: resp_valid 2 cycles after accept, y=0x7FF, cc=000, id=0.
//   2. Simultaneous requests, both valid from reset:
//      - Stimulus: req0 ADD 5+3, req1 SUB 5-7.
//      - Response: req0 served first (y=8); then req1 (y=0xFFFF_FFFF_FFFF_FFFE, SF=1).
//      - The third grant goes back to req0.
//   3. Overflow:
//      - ADD 0x7FFF_FFFF_FFFF_FFFF+1 -> y=0x8000_0000_0000_0000, cc={OF=1,SF=1,ZF=0}.
//      - SUB 0x8000_0000_0000_0000-1 -> OF=1, SF=0.
//   4. Backpressure:
//      - Stimulus: hold resp_ready=0 for 5 cycles during RESP.
//      - Response: resp_* stable; req0_ready and req1_ready stay 0 while req1_valid is held.
//   5. Reset mid-op:
//      - Stimulus: assert rst while in EXEC.
//      - Response: outputs 0 immediately (async); no response after release; next op uses rr_ptr=0.
//   6. XOR zero:
//      - Stimulus: XOR a=b=0xDEAD_BEEF.
//      - Response: y=0, ZF=1, OF=0.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the shared-ALU controller and its datapath.
//   - alu_fn_e     : ALU operation codes (ADD/SUB/AND/XOR)
//   - alu_state_e  : controller FSM state encoding
//   - CC_*         : bit positions inside the 3-bit condition-code vector
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        FN_ADD = 2'd0,
        FN_SUB = 2'd1,
        FN_AND = 2'd2,
        FN_XOR = 2'd3
    } alu_fn_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } alu_state_e;

    localparam int CC_ZF = 0;
    localparam int CC_SF = 1;
    localparam int CC_OF = 2;
    localparam int CC_W  = 3;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl_if
//   Bundles the two requester ports and the response port of the shared ALU.
//   Ports (per requester N in {0,1}):
//     reqN_valid  requester has an operation
//     reqN_ready  operation accepted this cycle
//     reqN_fn     op code (0 ADD, 1 SUB, 2 AND, 3 XOR)
//     reqN_a/b    operands
//   Response:
//     resp_valid / resp_ready handshake, resp_id (issuing requester),
//     resp_y (result), resp_cc ({OF, SF, ZF})
//   Modports: master = requesters + response consumer, slave = controller.
// ---------------------------------------------------------------------------
interface alu_share_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_fn;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_fn;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_y;
    logic [2:0]       resp_cc;

    modport master (
        output req0_valid, req0_fn, req0_a, req0_b,
        output req1_valid, req1_fn, req1_a, req1_b,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_y, resp_cc
    );

    modport slave (
        input  req0_valid, req0_fn, req0_a, req0_b,
        input  req1_valid, req1_fn, req1_a, req1_b,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_y, resp_cc
    );
endinterface

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
//   Purely combinational ALU with Y86-style condition codes.
//   Ports:
//     i_fn   operation (ADD/SUB/AND/XOR)
//     i_a    operand A
//     i_b    operand B
//     o_y    result, modulo 2^WIDTH (carry-out discarded)
//     o_cc   condition codes, indexed by CC_ZF/CC_SF/CC_OF
// ---------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  alu_fn_e          i_fn,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y,
    output logic [CC_W-1:0]  o_cc
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_xor;
    logic [WIDTH-1:0] w_y;
    logic             w_of;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic_bit
        assign w_and[gi] = i_a[gi] & i_b[gi];
        assign w_xor[gi] = i_a[gi] ^ i_b[gi];
    end

    // Signed overflow: ADD overflows when like-signed operands give a result
    // of the other sign; SUB when unlike-signed operands give a result whose
    // sign differs from A. Logical ops never overflow.
    always_comb begin
        w_y  = w_sum;
        w_of = 1'b0;
        case (i_fn)
            FN_ADD: begin
                w_y  = w_sum;
                w_of = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
            end
            FN_SUB: begin
                w_y  = w_diff;
                w_of = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
            end
            FN_AND: w_y = w_and;
            FN_XOR: w_y = w_xor;
            default: begin
                w_y  = w_sum;
                w_of = 1'b0;
            end
        endcase
    end

    assign o_y         = w_y;
    assign o_cc[CC_ZF] = (w_y == '0);
    assign o_cc[CC_SF] = w_y[MSB];
    assign o_cc[CC_OF] = w_of;

endmodule

// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl
//   Shares one ALU between two requesters (0 = execute stage, 1 = address /
//   PC-update path). One operation is in flight at a time:
//   IDLE (grant + capture) -> EXEC (ALU evaluates, result registered)
//   -> RESP (hold result until consumer takes it) -> IDLE.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous reset, active-high
//     bus   alu_share_ctrl_if slave modport (requests in, response out)
// ---------------------------------------------------------------------------
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic           clk,
    input  logic           rst,
    alu_share_ctrl_if.slave bus
);
    alu_state_e       r_state;
    logic             r_rr_ptr;
    alu_fn_e          r_fn;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic [WIDTH-1:0] r_y;
    logic [CC_W-1:0]  r_cc;
    logic             r_resp_valid;
    logic             r_resp_id;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_idle;
    logic [1:0]       w_sel_fn;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [WIDTH-1:0] w_y;
    logic [CC_W-1:0]  w_cc;

    // Round-robin grant: the pointed-to requester wins if it is asking,
    // otherwise the other one may take the slot.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!r_rr_ptr) begin
            w_gnt0 = bus.req0_valid;
            w_gnt1 = !bus.req0_valid && bus.req1_valid;
        end else begin
            w_gnt1 = bus.req1_valid;
            w_gnt0 = !bus.req1_valid && bus.req0_valid;
        end
    end

    always_comb begin
        w_sel_fn = bus.req0_fn;
        w_sel_a  = bus.req0_a;
        w_sel_b  = bus.req0_b;
        if (w_gnt1) begin
            w_sel_fn = bus.req1_fn;
            w_sel_a  = bus.req1_a;
            w_sel_b  = bus.req1_b;
        end
    end

    assign w_idle = (r_state == ST_IDLE);

    // Ready is forced low while reset is held so every output reads 0.
    assign bus.req0_ready = w_idle && w_gnt0 && !rst;
    assign bus.req1_ready = w_idle && w_gnt1 && !rst;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .i_fn (r_fn),
        .i_a  (r_a),
        .i_b  (r_b),
        .o_y  (w_y),
        .o_cc (w_cc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= 1'b0;
            r_fn         <= FN_ADD;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_y          <= '0;
            r_cc         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_fn    <= alu_fn_e'(w_sel_fn);
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_id    <= w_gnt1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_y          <= w_y;
                    r_cc         <= w_cc;
                    r_resp_id    <= r_id;
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    // Flip priority to whoever did not just finish, so a
                    // requester left waiting wins the next grant.
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_rr_ptr     <= ~r_resp_id;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_y     = r_y;
    assign bus.resp_cc    = r_cc;

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_share_ctrl_if #(.WIDTH(W)) bus ();

    alu_share_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          id;
        logic [W-1:0]  y;
        logic [2:0]    cc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input logic id, input logic [W-1:0] y, input logic [2:0] cc);
        exp_t e;
        e.id = id;
        e.y  = y;
        e.cc = cc;
        sb.push_back(e);
    endtask

    task automatic set_req(input int id, input logic [1:0] fn,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 0) begin
            bus.req0_valid = 1'b1;
            bus.req0_fn    = fn;
            bus.req0_a     = a;
            bus.req0_b     = b;
        end else begin
            bus.req1_valid = 1'b1;
            bus.req1_fn    = fn;
            bus.req1_a     = a;
            bus.req1_b     = b;
        end
    endtask

    task automatic drop_req(input int id);
        if (id == 0) bus.req0_valid = 1'b0;
        else         bus.req1_valid = 1'b0;
    endtask

    // Waits for ready on requester id, then lets the accept edge pass and
    // drops valid; returns 1 time unit into the EXEC cycle.
    task automatic wait_accept(input int id);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if ((id == 0 && bus.req0_ready) || (id == 1 && bus.req1_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: requester %0d never saw ready, required ready within 30 cycles", id);
        end
        @(posedge clk);
        #1;
        drop_req(id);
    endtask

    // Waits until every expected response has been taken; returns just after
    // the handshake edge, so the controller is back in IDLE.
    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        #1;
    endtask

    // Monitor: a response transfers on the next rising edge whenever
    // valid&&ready is seen here, so each one is compared exactly once.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.resp_valid && bus.resp_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_resp: got id=%0d y=%h cc=%b, required no response",
                             bus.resp_id, bus.resp_y, bus.resp_cc);
                end else begin
                    e = sb.pop_front();
                    $display("resp: id=%0d y=%h cc=%b (expected id=%0d y=%h cc=%b)",
                             bus.resp_id, bus.resp_y, bus.resp_cc, e.id, e.y, e.cc);
                    chk("resp_id", 64'(bus.resp_id), 64'(e.id));
                    chk("resp_y",  bus.resp_y, e.y);
                    chk("resp_cc", 64'(bus.resp_cc), 64'(e.cc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req0_valid = 1'b0; bus.req0_fn = 2'd0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_fn = 2'd0; bus.req1_a = '0; bus.req1_b = '0;
        bus.resp_ready = 1'b1;
        rst = 1'b1;

        // Reset state, including ready held low with a valid pending
        repeat (2) @(negedge clk);
        bus.req0_valid = 1'b1;
        #1;
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_y",     bus.resp_y, 64'd0);
        chk("rst_resp_cc",    64'(bus.resp_cc), 64'd0);
        chk("rst_resp_id",    64'(bus.resp_id), 64'd0);
        chk("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
        bus.req0_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // 1. Single AND, response two cycles after accept
        push(1'b0, 64'h7FF, 3'b000);
        set_req(0, FN_AND, 64'h3F_FFFF, 64'h7FF);
        wait_accept(0);
        @(negedge clk);
        chk("t1_valid_at_n1", 64'(bus.resp_valid), 64'd0);
        @(negedge clk);
        chk("t1_valid_at_n2", 64'(bus.resp_valid), 64'd1);
        wait_drain();

        // 2. Both valid from reset: req0 first, req1 next, then req0 again
        rst = 1'b1;
        set_req(0, FN_ADD, 64'd5, 64'd3);
        set_req(1, FN_SUB, 64'd5, 64'd7);
        push(1'b0, 64'd8, 3'b000);
        push(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t2_first_gnt_req0", 64'(bus.req0_ready), 64'd1);
        chk("t2_first_req1_wait", 64'(bus.req1_ready), 64'd0);
        @(posedge clk); #1 drop_req(0);
        wait_accept(1);
        wait_drain();
        set_req(0, FN_ADD, 64'd1, 64'd1);
        set_req(1, FN_XOR, 64'hF0, 64'hFF);
        push(1'b0, 64'd2, 3'b000);
        push(1'b1, 64'h0F, 3'b000);
        @(negedge clk);
        chk("t2_third_gnt_req0", 64'(bus.req0_ready), 64'd1);
        chk("t2_third_req1_wait", 64'(bus.req1_ready), 64'd0);
        @(posedge clk); #1 drop_req(0);
        wait_accept(1);
        wait_drain();

        // 3. Overflow and wrap-around
        push(1'b0, 64'h8000_0000_0000_0000, 3'b110);
        set_req(0, FN_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        wait_accept(0);
        wait_drain();
        push(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b100);
        set_req(1, FN_SUB, 64'h8000_0000_0000_0000, 64'd1);
        wait_accept(1);
        wait_drain();
        push(1'b0, 64'd0, 3'b001);
        set_req(0, FN_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        wait_accept(0);
        wait_drain();

        // 4. Backpressure: response held stable, no grants while busy
        bus.resp_ready = 1'b0;
        push(1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 3'b010);
        set_req(0, FN_SUB, 64'd3, 64'd10);
        wait_accept(0);
        set_req(1, FN_ADD, 64'd2, 64'd2);
        push(1'b1, 64'd4, 3'b000);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (bus.resp_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) begin
                n_cmp++;
                n_err++;
                $display("FAIL t4_resp_timeout: resp_valid=0, required 1 within 10 cycles");
            end
        end
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid",  64'(bus.resp_valid), 64'd1);
            chk("t4_hold_y",      bus.resp_y, 64'hFFFF_FFFF_FFFF_FFF9);
            chk("t4_hold_cc",     64'(bus.resp_cc), 64'(3'b010));
            chk("t4_hold_id",     64'(bus.resp_id), 64'd0);
            chk("t4_req0_ready",  64'(bus.req0_ready), 64'd0);
            chk("t4_req1_ready",  64'(bus.req1_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1 bus.resp_ready = 1'b1;
        wait_accept(1);
        wait_drain();

        // 6. XOR of equal operands (leaves rr_ptr pointing at req1)
        push(1'b0, 64'd0, 3'b001);
        set_req(0, FN_XOR, 64'hDEAD_BEEF, 64'hDEAD_BEEF);
        wait_accept(0);
        wait_drain();

        // 5. Reset during EXEC: op dropped, outputs cleared, rr_ptr back to 0
        set_req(1, FN_ADD, 64'd1, 64'd1);
        wait_accept(1);
        set_req(0, FN_ADD, 64'd1, 64'd2);
        set_req(1, FN_SUB, 64'd3, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("t5_rst_resp_y",     bus.resp_y, 64'd0);
        chk("t5_rst_resp_cc",    64'(bus.resp_cc), 64'd0);
        chk("t5_rst_resp_id",    64'(bus.resp_id), 64'd0);
        chk("t5_rst_req0_ready", 64'(bus.req0_ready), 64'd0);
        chk("t5_rst_req1_ready", 64'(bus.req1_ready), 64'd0);
        push(1'b0, 64'd3, 3'b000);
        push(1'b1, 64'd2, 3'b000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_post_gnt_req0",  64'(bus.req0_ready), 64'd1);
        chk("t5_post_req1_wait", 64'(bus.req1_ready), 64'd0);
        chk("t5_post_no_valid",  64'(bus.resp_valid), 64'd0);
        @(posedge clk); #1 drop_req(0);
        wait_accept(1);
        wait_drain();

        repeat (4) @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL leftover_expect: %0d responses never seen, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
